nn_xor_scheduler: RTL and testbench
===================================

Name: nn_xor_scheduler

Overview:
Sequences a single floating-point XOR neural-network core (2-2-1, IEEE-754 single precision) and shares it between N_REQ requesters. Each requester submits an (A, B) input pair over a valid/ready handshake. The scheduler arbitrates round-robin, launches one inference at a time, guards the core with a timeout watchdog, and returns the result, the requester id and a "greater than 0.5" decision on one shared response channel.

Parameters:
- DATA_WIDTH, 32, operand/result width (exp 8 + mant 24).
- N_REQ, 2, number of requesters (2..8).
- ID_W, $clog2(N_REQ) (min 1), width of the requester id.
- TIMEOUT, 64, maximum cycles spent in WAIT before the core is flushed.

Ports:
- clk, in, 1, single clock, rising edge.
- rst_l, in, 1, synchronous active-low reset.
- cfg_round_mode, in, 3, rounding mode sampled at request accept.
- req_valid, in, N_REQ, per-requester request valid.
- req_ready, out, N_REQ, per-requester accept (one-hot or zero).
- req_a, in, N_REQ*DATA_WIDTH, packed A operands; requester i at [i*DW +: DW].
- req_b, in, N_REQ*DATA_WIDTH, packed B operands.
- resp_valid, out, 1, response valid.
- resp_ready, in, 1, response consumer ready.
- resp_id, out, ID_W, requester that owns this response.
- resp_data, out, DATA_WIDTH, core result.
- resp_gt_half, out, 1, resp_data > 0.5 as a float.
- resp_timeout, out, 1, the core did not finish in time.
- core_a, out, DATA_WIDTH, core input A.
- core_b, out, DATA_WIDTH, core input B.
- core_round_mode, out, 3, core rounding mode.
- core_start, out, 1, single-cycle launch pulse.
- core_done, in, 1, single-cycle completion pulse from the core.
- core_result, in, DATA_WIDTH, core output, valid when core_done=1.
- core_rst_l, out, 1, core reset: rst_l AND NOT flush.
- busy, out, 1, high whenever the state is not IDLE.

Behaviour:
- Reset (rst_l=0 at a clock edge):
  - state=IDLE; rr_ptr=0.
  - All outputs 0, except core_rst_l, which follows rst_l (0).
- States:
  - IDLE: grant the first requester with req_valid=1, searching from rr_ptr upward with wrap. req_ready[g] is asserted combinationally for the granted requester only. On the handshake, latch A, B, cfg_round_mode and g; set rr_ptr=g+1 mod N_REQ; go to ISSUE. With no valid request, stay in IDLE.
  - ISSUE: core_start=1 for exactly one cycle; clear the wait counter; go to WAIT.
  - WAIT: the counter increments every cycle.
    - On core_done, capture core_result, clear the timeout flag, go to RESP.
    - If the counter reaches TIMEOUT-1 with core_done=0, go to FLUSH.
    - If core_done arrives in the same cycle the counter reaches TIMEOUT-1, done wins.
  - FLUSH: core_rst_l=0 for exactly 2 cycles. Then load result=0 and timeout=1, go to RESP.
  - RESP: resp_valid=1 with resp_id, resp_data, resp_gt_half and resp_timeout held stable. On resp_valid & resp_ready, go to IDLE; the next grant is possible only from the following cycle.
- core_a, core_b and core_round_mode hold the latched values from ISSUE through the end of RESP. They are 0 in IDLE.
- resp_gt_half = (sign bit == 0) AND (bits[30:0] > 31'h3F000000). Exactly 0.5 gives 0; NaN with sign 0 gives 1; -0 gives 0.
- A core_done seen outside WAIT is ignored.
- Latency: accept at cycle T → core_start at T+1 → core_done at T+1+L → resp_valid at T+2+L.
- Reset mid-operation: any state returns to IDLE with no response emitted. An in-flight request is lost.
- Fairness: a continuously valid requester waits at most N_REQ-1 inferences.

Optional Feature:
NN_SCHED_PERF_EN
- Defined: adds outputs perf_count (32 bits, saturating count of completed responses, including timeouts) and perf_max_lat (16 bits, largest ISSUE-to-done cycle count). Both are cleared by rst_l.
- Undefined: neither port nor the counters exist.

Decomposition:
- Package nn_sched_pkg:
  - state enum sched_state_t {IDLE, ISSUE, WAIT, FLUSH, RESP};
  - localparam FP_HALF = 32'h3F000000;
  - function fp_gt_half().
- Sub-module nn_rr_arbiter (req vector, rr_ptr → one-hot grant plus index), reusable by other shared-FPU blocks.

Test Plan:
- Single request: req0 A=32'h00000000, B=32'h3F800000; core stub returns 32'h3F7A0000 after L=40.
  - core_start exactly 1 cycle after accept.
  - resp_valid at T+42 with resp_id=0, resp_data=32'h3F7A0000, resp_gt_half=1, resp_timeout=0.
- Contention: req0 and req1 both valid continuously for 4 inferences → grant order 0, 1, 0, 1; never two req_ready bits high together.
- Timeout: stub never pulses done, TIMEOUT=64.
  - core_rst_l low for exactly 2 cycles after 64 WAIT cycles.
  - Response has resp_timeout=1, resp_data=0.
  - Next request completes normally.
- Threshold boundaries: core_result 32'h3F000000 → gt_half=0; 32'h3F000001 → 1; 32'hBF800000 → 0; 32'h80000000 → 0.
- Backpressure and done/timeout race:
  - Hold resp_ready=0 for 10 cycles → outputs stable, no new grant.
  - Done in the same cycle the counter reaches TIMEOUT-1 → resp_timeout=0.
- Reset mid-WAIT: drop rst_l for 1 cycle → state IDLE, busy=0, resp_valid=0, rr_ptr=0, no stale response afterwards.

Source files
------------

// File: rtl/nn_xor_scheduler_pkg.sv
// nn_sched_pkg: shared types and helpers for the XOR-network core scheduler.
//   sched_state_t : scheduler FSM states
//   FP_HALF       : IEEE-754 single-precision 0.5
//   fp_gt_half()  : strict "x > 0.5" test on the raw float bits
package nn_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        FLUSH,
        RESP
    } sched_state_t;

    localparam logic [31:0] FP_HALF = 32'h3F00_0000;

    // Positive floats order the same way as their magnitude bits, so a plain
    // unsigned compare works. A positive NaN sits above 0.5 and reads as 1;
    // every negative value, including -0, reads as 0.
    function automatic logic fp_gt_half(input logic [31:0] x);
        return ~x[31] && (x[30:0] > FP_HALF[30:0]);
    endfunction

endpackage

// File: rtl/nn_xor_scheduler_if.sv
// nn_xor_scheduler_if: request/response bus between requesters and the scheduler.
//   cfg_round_mode        : rounding mode, sampled when a request is accepted
//   req_valid/req_ready   : per-requester handshake (req_ready one-hot or zero)
//   req_a/req_b           : packed operands, requester i in row [i]
//   resp_valid/resp_ready : shared response handshake
//   resp_id/resp_data/resp_gt_half/resp_timeout : response payload
// master = requester side, slave = scheduler side.
interface nn_xor_scheduler_if #(
    parameter int N_REQ      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) ();

    logic [2:0]                           cfg_round_mode;
    logic [N_REQ-1:0]                     req_valid;
    logic [N_REQ-1:0]                     req_ready;
    logic [N_REQ-1:0][DATA_WIDTH-1:0]     req_a;
    logic [N_REQ-1:0][DATA_WIDTH-1:0]     req_b;
    logic                                 resp_valid;
    logic                                 resp_ready;
    logic [ID_W-1:0]                      resp_id;
    logic [DATA_WIDTH-1:0]                resp_data;
    logic                                 resp_gt_half;
    logic                                 resp_timeout;

    modport master (
        output cfg_round_mode, req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data, resp_gt_half, resp_timeout
    );

    modport slave (
        input  cfg_round_mode, req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data, resp_gt_half, resp_timeout
    );

endinterface

// File: rtl/nn_xor_scheduler_rr_arbiter.sv
// nn_rr_arbiter: round-robin pick of the first set request at or above ptr_i,
// wrapping at N. Purely combinational; the owner keeps the pointer.
//   req_i   : request vector
//   ptr_i   : highest-priority index
//   grant_o : one-hot grant (zero when no request)
//   idx_o   : index of the granted request
//   any_o   : at least one request present
module nn_rr_arbiter
    import nn_sched_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] j;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = '0;
        for (int i = 0; i < N; i++) begin
            j = IDX_W'((int'(ptr_i) + i) % N);
            if (!any_o && req_i[j]) begin
                grant_o[j] = 1'b1;
                idx_o      = j;
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nn_xor_scheduler.sv
// nn_xor_scheduler: shares one 2-2-1 float XOR network core between N_REQ
// requesters. Round-robin grant, one inference in flight, watchdog flush of a
// hung core, single shared response channel.
//   clk, rst_l       : clock, synchronous active-low reset
//   bus (slave)      : request/response bus, see nn_xor_scheduler_if
//   core_a/b, core_round_mode, core_start : core launch side
//   core_done, core_result                : core completion side
//   core_rst_l       : core reset, also pulsed low for 2 cycles on timeout
//   busy             : FSM not idle
// Optional build macro NN_SCHED_PERF_EN adds perf_count (saturating count of
// completed responses) and perf_max_lat (largest ISSUE-to-done latency).
module nn_xor_scheduler
    import nn_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ      = 2,
    parameter int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst_l,
    nn_xor_scheduler_if.slave     bus,
    output logic [DATA_WIDTH-1:0] core_a,
    output logic [DATA_WIDTH-1:0] core_b,
    output logic [2:0]            core_round_mode,
    output logic                  core_start,
    input  logic                  core_done,
    input  logic [DATA_WIDTH-1:0] core_result,
    output logic                  core_rst_l,
    output logic                  busy
`ifdef NN_SCHED_PERF_EN
    ,
    output logic [31:0]           perf_count,
    output logic [15:0]           perf_max_lat
`endif
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    sched_state_t          state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [2:0]            rm_q, rm_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  fl_q, fl_d;
    logic                  timeout_q, timeout_d;

    logic [N_REQ-1:0]      gnt;
    logic [ID_W-1:0]       gnt_idx;
    logic                  gnt_any;

    nn_rr_arbiter #(.N(N_REQ), .IDX_W(ID_W)) u_arb (
        .req_i   (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (gnt),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        rm_d      = rm_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        fl_d      = fl_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                // req_ready mirrors the grant, so a grant is the handshake.
                if (gnt_any) begin
                    a_d      = bus.req_a[gnt_idx];
                    b_d      = bus.req_b[gnt_idx];
                    rm_d     = bus.cfg_round_mode;
                    id_d     = gnt_idx;
                    rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // done is tested first so it wins a tie with the watchdog.
                if (core_done) begin
                    result_d  = core_result;
                    timeout_d = 1'b0;
                    state_d   = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    fl_d    = 1'b0;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                fl_d = 1'b1;
                if (fl_q) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rm_q      <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            fl_q      <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rm_q      <= rm_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            fl_q      <= fl_d;
            timeout_q <= timeout_d;
        end
    end

    // Gated by rst_l so nothing is offered while reset is held.
    assign bus.req_ready = (state_q == IDLE && rst_l) ? gnt : '0;

    assign core_start      = (state_q == ISSUE);
    assign core_a          = (state_q != IDLE) ? a_q  : '0;
    assign core_b          = (state_q != IDLE) ? b_q  : '0;
    assign core_round_mode = (state_q != IDLE) ? rm_q : '0;
    assign core_rst_l      = rst_l & (state_q != FLUSH);
    assign busy            = (state_q != IDLE);

    assign bus.resp_valid   = (state_q == RESP);
    assign bus.resp_id      = (state_q == RESP) ? id_q : '0;
    assign bus.resp_data    = (state_q == RESP) ? result_q : '0;
    assign bus.resp_gt_half = (state_q == RESP) && fp_gt_half(result_q);
    assign bus.resp_timeout = (state_q == RESP) && timeout_q;

`ifdef NN_SCHED_PERF_EN
    logic [31:0] perf_cnt_q;
    logic [15:0] perf_lat_q;
    logic [15:0] lat_now;

    // ISSUE is one cycle before WAIT count 0, hence the +1.
    assign lat_now = 16'(cnt_q) + 16'd1;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            perf_cnt_q <= '0;
            perf_lat_q <= '0;
        end else begin
            if (state_q == RESP && bus.resp_ready && perf_cnt_q != '1)
                perf_cnt_q <= perf_cnt_q + 32'd1;
            if (state_q == WAIT && core_done && lat_now > perf_lat_q)
                perf_lat_q <= lat_now;
        end
    end

    assign perf_count   = perf_cnt_q;
    assign perf_max_lat = perf_lat_q;
`endif

endmodule

// File: tb/tb_nn_xor_scheduler.sv
// Directed bench for nn_xor_scheduler with a latency-programmable core stub
// and a response scoreboard.
module tb_nn_xor_scheduler;

    localparam int N_REQ   = 2;
    localparam int DW      = 32;
    localparam int ID_W    = 1;
    localparam int TIMEOUT = 64;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        gt;
        logic        to;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_l = 1'b0;
    logic [DW-1:0] core_a, core_b;
    logic [DW-1:0] core_result = 32'h1234_5678;
    logic [2:0]    core_round_mode;
    logic          core_start, core_rst_l, busy;
    logic          core_done = 1'b0;
`ifdef NN_SCHED_PERF_EN
    logic [31:0]   perf_count;
    logic [15:0]   perf_max_lat;
`endif

    nn_xor_scheduler_if #(.N_REQ(N_REQ), .DATA_WIDTH(DW), .ID_W(ID_W)) bus ();

    nn_xor_scheduler #(
        .DATA_WIDTH (DW),
        .N_REQ      (N_REQ),
        .ID_W       (ID_W),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .bus             (bus),
        .core_a          (core_a),
        .core_b          (core_b),
        .core_round_mode (core_round_mode),
        .core_start      (core_start),
        .core_done       (core_done),
        .core_result     (core_result),
        .core_rst_l      (core_rst_l),
        .busy            (busy)
`ifdef NN_SCHED_PERF_EN
        ,
        .perf_count      (perf_count),
        .perf_max_lat    (perf_max_lat)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int   n_asserts = 0;
    int   n_fail = 0;
    int   acc_cyc = 0;
    exp_t exp_q[$];

    // Core stub: done (with stub_result) stub_lat cycles after core_start;
    // stub_lat == 0 means the core hangs. Junk on core_result otherwise.
    int          stub_lat = 0;
    logic [31:0] stub_result = '0;
    int          cd = -1;

    always @(posedge clk) begin
        core_done   <= 1'b0;
        core_result <= 32'h1234_5678;
        if (core_start) begin
            if (stub_lat == 1) begin
                core_done   <= 1'b1;
                core_result <= stub_result;
            end else if (stub_lat > 1) cd <= stub_lat - 1;
            else cd <= -1;
        end else if (cd > 1) begin
            cd <= cd - 1;
        end else if (cd == 1) begin
            core_done   <= 1'b1;
            core_result <= stub_result;
            cd          <= -1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) chk("req_ready_onehot", 64'($countones(bus.req_ready) <= 1), 1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [31:0] d, input logic gt, input logic to);
        exp_t e;
        e.id = id; e.data = d; e.gt = gt; e.to = to;
        exp_q.push_back(e);
    endtask

    task automatic wait_grant(output int g);
        g = -1;
        for (int k = 0; k < 50; k++) begin
            if (bus.req_ready != '0) begin
                for (int i = 0; i < N_REQ; i++) if (bus.req_ready[i]) g = i;
                break;
            end
            tick();
        end
        chk("grant_seen", 64'(g >= 0), 1);
    endtask

    // Raise req_valid[idx], wait for its grant, take the accept edge and
    // check the one-cycle core_start pulse and the latched operands.
    task automatic send(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] rm, input bit keep);
        int g;
        bus.req_valid[idx]  = 1'b1;
        bus.req_a[idx]      = a;
        bus.req_b[idx]      = b;
        bus.cfg_round_mode  = rm;
        #1;
        wait_grant(g);
        chk("grant_idx", 64'(g), 64'(idx));
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!keep) bus.req_valid[idx] = 1'b0;
        chk("core_start_issue", core_start, 1);
        chk("core_a", core_a, a);
        chk("core_b", core_b, b);
        chk("core_round_mode", core_round_mode, rm);
        tick();
        chk("core_start_pulse", core_start, 0);
    endtask

    // Wait for resp_valid, compare with the scoreboard head, optionally hold
    // resp_ready low for 'hold' cycles, then complete the handshake.
    task automatic wait_resp(input int exp_lat, input int hold);
        int   n = 0;
        exp_t e;
        while (!bus.resp_valid && n < 300) begin
            tick();
            n++;
        end
        chk("resp_seen", bus.resp_valid, 1);
        if (exp_lat >= 0) chk("resp_latency", 64'(cyc - acc_cyc), 64'(exp_lat));
        chk("sb_nonempty", 64'(exp_q.size() > 0), 1);
        e.id = -1; e.data = 'x; e.gt = 'x; e.to = 'x;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) tick();
            chk("resp_valid_hold", bus.resp_valid, 1);
            chk("resp_id", 64'(bus.resp_id), 64'(e.id));
            chk("resp_data", bus.resp_data, e.data);
            chk("resp_gt_half", bus.resp_gt_half, e.gt);
            chk("resp_timeout", bus.resp_timeout, e.to);
            if (hold > 0) chk("no_grant_in_resp", bus.req_ready, 0);
        end
        bus.resp_ready = 1'b1;
        tick();
        chk("resp_valid_drop", bus.resp_valid, 0);
        chk("busy_after_resp", busy, 0);
    endtask

    logic [31:0] thr_v [5] = '{32'h3F00_0000, 32'h3F00_0001, 32'hBF80_0000,
                               32'h8000_0000, 32'h7FC0_0000};
    logic        thr_g [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        bit stale;
        bus.req_valid      = '0;
        bus.req_a          = '0;
        bus.req_b          = '0;
        bus.cfg_round_mode = '0;
        bus.resp_ready     = 1'b1;

        // Reset state
        rst_l = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_rst_l", core_rst_l, 0);
        chk("rst_core_a", core_a, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        rst_l = 1'b1;
        tick();
        chk("core_rst_l_run", core_rst_l, 1);

        // Single request, L = 40
        stub_lat = 40; stub_result = 32'h3F7A_0000;
        push(0, 32'h3F7A_0000, 1'b1, 1'b0);
        send(0, 32'h0000_0000, 32'h3F80_0000, 3'd2, 1'b0);
        wait_resp(41, 0);

        // Contention from a fresh pointer: 0,1,0,1
        rst_l = 1'b0; tick(); rst_l = 1'b1; tick();
        bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            stub_lat = 3 + k;
            stub_result = 32'h3F10_0000 + 32'(k);
            push(k % 2, 32'h3F10_0000 + 32'(k), 1'b1, 1'b0);
            send(k % 2, 32'(k), 32'(k + 10), 3'(k), 1'b1);
            wait_resp(4 + k, 0);
        end
        bus.req_valid = '0;

        // Timeout: core never completes
        stub_lat = 0;
        push(0, 32'h0, 1'b0, 1'b1);
        send(0, 32'h3F80_0000, 32'h3F80_0000, 3'd1, 1'b0);
        n = 0;
        while (core_rst_l && n < 200) begin tick(); n++; end
        chk("wait_cycles_before_flush", 64'(n), 64);
        n = 0;
        while (!core_rst_l && n < 10) begin tick(); n++; end
        chk("flush_len", 64'(n), 2);
        wait_resp(67, 0);

        // Normal request right after a timeout
        stub_lat = 5; stub_result = 32'h3E80_0000;
        push(1, 32'h3E80_0000, 1'b0, 1'b0);
        send(1, 32'h3F80_0000, 32'h0000_0000, 3'd0, 1'b0);
        wait_resp(6, 0);

        // Threshold boundaries
        for (int i = 0; i < 5; i++) begin
            stub_lat = 2; stub_result = thr_v[i];
            push(0, thr_v[i], thr_g[i], 1'b0);
            send(0, 32'(i), 32'(i), 3'd0, 1'b0);
            wait_resp(3, 0);
        end

        // Backpressure with a pending request that must not be granted
        stub_lat = 3; stub_result = 32'h3F40_0000;
        push(0, 32'h3F40_0000, 1'b1, 1'b0);
        send(0, 32'h1, 32'h2, 3'd3, 1'b0);
        bus.req_valid[1] = 1'b1;
        bus.resp_ready = 1'b0;
        wait_resp(4, 10);
        chk("grant_after_resp", bus.req_ready, 2'b10);
        stub_lat = 4; stub_result = 32'h3F20_0000;
        push(1, 32'h3F20_0000, 1'b1, 1'b0);
        send(1, 32'h3, 32'h4, 3'd4, 1'b0);
        wait_resp(5, 0);

        // Done in the same cycle the watchdog expires
        stub_lat = TIMEOUT; stub_result = 32'h3F00_0001;
        push(1, 32'h3F00_0001, 1'b1, 1'b0);
        send(1, 32'h5, 32'h6, 3'd5, 1'b0);
        wait_resp(TIMEOUT + 1, 0);

        // Reset mid-WAIT; the stub's late done lands in IDLE and is ignored
        stub_lat = 30; stub_result = 32'h3F7F_0000;
        send(0, 32'h7, 32'h8, 3'd6, 1'b0);
        repeat (5) tick();
        rst_l = 1'b0;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_resp_valid", bus.resp_valid, 0);
        chk("midrst_core_rst_l", core_rst_l, 0);
        rst_l = 1'b1;
        tick();
        stale = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.resp_valid || busy) stale = 1'b1;
            tick();
        end
        chk("no_stale_response", stale, 0);
        // Pointer was 1 before reset; both valid must now grant 0
        bus.req_valid[1] = 1'b1;
        stub_lat = 3; stub_result = 32'h3F30_0000;
        push(0, 32'h3F30_0000, 1'b1, 1'b0);
        send(0, 32'h9, 32'hA, 3'd7, 1'b0);
        bus.req_valid[1] = 1'b0;
        wait_resp(4, 0);

        chk("sb_empty", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
